// File: rtl/handshake_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : handshake_sequencer
// Brief   : 4-phase request/ack interface FSM for the stream-cipher input
//           reader, with request synchronizer and bounded downstream wait.
// Revision: 1.0 - initial release
// ============================================================================
module handshake_sequencer #(
    parameter int SYNC_STAGES    = 2,   // minimum 2
    parameter int TIMEOUT_CYCLES = 255  // minimum 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       input_request,
    input  logic       op_done,
    output logic       input_request_sync,
    output logic [1:0] fsm_state,
    output logic       input_ack,
    output logic       op_error,
    output logic       busy
);

    localparam int                CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PROCESS  = 2'd1,
        ACK      = 2'd2,
        RESERVED = 2'd3
    } interface_state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    interface_state_t       state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic                   req_sync;

    assign req_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], input_request};
        end
    end

    // Leaving IDLE on the edge the reader pulses guarantees one pulse per request;
    // ACK is left only on request release, so every operation needs a fresh rise.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_sync) begin
                    state_d = PROCESS;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            PROCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_done) begin
                    state_d = ACK;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ACK;
                    err_d   = 1'b1;
                end
            end
            ACK: begin
                if (!req_sync) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ack_d = (state_d == ACK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign input_request_sync = req_sync;
    assign fsm_state          = state_q;
    assign busy               = (state_q != IDLE);
    assign input_ack          = ack_q;
    assign op_error           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_handshake_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_handshake_sequencer
// Brief   : Self-checking bench; per-transaction timeline model of the handshake.
// Revision: 1.0 - initial release
// ============================================================================
module tb_handshake_sequencer;

    localparam int SYNC = 2;
    localparam int T    = 8;
    localparam int MAXT = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       input_request = 1'b0;
    logic       op_done = 1'b0;
    logic       input_request_sync;
    logic [1:0] fsm_state;
    logic       input_ack;
    logic       op_error;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Per-tick snapshot {sync, state[1:0], ack, err, busy}, tick 0 = transaction start
    logic [5:0] exp_v [0:MAXT-1];
    logic [5:0] obs_v [0:MAXT-1];
    int         txn_len;
    bit         txn_err;
    bit         last_err;

    handshake_sequencer #(
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .input_request      (input_request),
        .op_done            (op_done),
        .input_request_sync (input_request_sync),
        .fsm_state          (fsm_state),
        .input_ack          (input_ack),
        .op_error           (op_error),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] pack_obs();
        return {input_request_sync, fsm_state, input_ack, op_error, busy};
    endfunction

    // Request pin high for edges 1..f; op_done pulse on PROCESS cycle d (0 = never).
    task automatic model_txn(input int d, input int f, input bit perr);
        bit         ok;
        int         dwell, ack_at, idle_at;
        logic [1:0] st;
        logic       sy, e;
        ok      = (d >= 1 && d <= T);
        dwell   = ok ? d : T;
        ack_at  = SYNC + 1 + dwell;
        idle_at = (ack_at + 1 > f + SYNC + 1) ? ack_at + 1 : f + SYNC + 1;
        txn_len = idle_at + 1;
        txn_err = !ok;
        for (int t = 0; t <= txn_len; t++) begin
            sy = (t >= SYNC && t <= f + SYNC - 1);
            if (t < SYNC + 1)     st = 2'd0;
            else if (t < ack_at)  st = 2'd1;
            else if (t < idle_at) st = 2'd2;
            else                  st = 2'd0;
            if (t < SYNC + 1)     e = perr;
            else if (t < ack_at)  e = 1'b0;
            else                  e = txn_err;
            exp_v[t] = {sy, st, (st == 2'd2), e, (st != 2'd0)};
        end
    endtask

    task automatic drive_txn(input int d, input int f, input bit spurious);
        obs_v[0] = pack_obs();
        for (int t = 1; t <= txn_len; t++) begin
            input_request = (t <= f);
            if (d > 0 && t == SYNC + 1 + d)
                op_done = 1'b1;
            else if (spurious && exp_v[t-1][4:3] != 2'd1)
                op_done = 1'($urandom_range(0, 1));
            else
                op_done = 1'b0;
            @(negedge clk);
            obs_v[t] = pack_obs();
        end
        input_request = 1'b0;
        op_done       = 1'b0;
    endtask

    task automatic test_reset();
        input_request = 1'b1;
        repeat (SYNC + 1) @(negedge clk);
        checks++;
        if (fsm_state !== 2'd1) begin
            errors++;
            $display("FAIL reset_pre_process: got state=%0d want 1", fsm_state);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (pack_obs() !== 6'b0) begin
            errors++;
            $display("FAIL reset_immediate: got %b want 000000 (sync,state,ack,err,busy)", pack_obs());
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_txn(4, 12, 1'b0);
        drive_txn(4, 12, 1'b0);
        for (int t = 0; t <= txn_len; t++) begin
            checks++;
            if (obs_v[t] !== exp_v[t]) begin
                errors++;
                $display("FAIL reset_release tick %0d: got %b want %b", t, obs_v[t], exp_v[t]);
            end
        end
        last_err = txn_err;
    endtask

    task automatic test_nominal();
        model_txn(5, 10, last_err);
        drive_txn(5, 10, 1'b0);
        for (int t = 0; t <= txn_len; t++) begin
            checks++;
            if (obs_v[t] !== exp_v[t]) begin
                errors++;
                $display("FAIL nominal tick %0d: got %b want %b", t, obs_v[t], exp_v[t]);
            end
        end
        last_err = txn_err;
    endtask

    task automatic test_timeout();
        model_txn(0, 15, last_err);
        drive_txn(0, 15, 1'b0);
        for (int t = 0; t <= txn_len; t++) begin
            checks++;
            if (obs_v[t] !== exp_v[t]) begin
                errors++;
                $display("FAIL timeout tick %0d: got %b want %b", t, obs_v[t], exp_v[t]);
            end
        end
        last_err = txn_err;
        model_txn(3, 8, last_err);
        drive_txn(3, 8, 1'b0);
        for (int t = 0; t <= txn_len; t++) begin
            checks++;
            if (obs_v[t] !== exp_v[t]) begin
                errors++;
                $display("FAIL timeout_clear tick %0d: got %b want %b", t, obs_v[t], exp_v[t]);
            end
        end
        last_err = txn_err;
    endtask

    task automatic test_simultaneous();
        model_txn(T, 14, last_err);
        drive_txn(T, 14, 1'b1);
        for (int t = 0; t <= txn_len; t++) begin
            checks++;
            if (obs_v[t] !== exp_v[t]) begin
                errors++;
                $display("FAIL simultaneous tick %0d: got %b want %b", t, obs_v[t], exp_v[t]);
            end
        end
        last_err = txn_err;
    endtask

    task automatic test_hold();
        int starts;
        model_txn(2, 25, last_err);
        drive_txn(2, 25, 1'b1);
        starts = 0;
        for (int t = 0; t <= txn_len; t++) begin
            checks++;
            if (obs_v[t] !== exp_v[t]) begin
                errors++;
                $display("FAIL hold tick %0d: got %b want %b", t, obs_v[t], exp_v[t]);
            end
            if (t > 0 && obs_v[t-1][4:3] == 2'd0 && obs_v[t][4:3] == 2'd1) starts++;
        end
        checks++;
        if (starts != 1) begin
            errors++;
            $display("FAIL hold_starts: got %0d operations want 1", starts);
        end
        last_err = txn_err;
    endtask

    task automatic test_early_drop();
        int ack_ticks;
        model_txn(6, 2, last_err);
        drive_txn(6, 2, 1'b0);
        ack_ticks = 0;
        for (int t = 0; t <= txn_len; t++) begin
            checks++;
            if (obs_v[t] !== exp_v[t]) begin
                errors++;
                $display("FAIL early_drop tick %0d: got %b want %b", t, obs_v[t], exp_v[t]);
            end
            if (obs_v[t][4:3] == 2'd2) ack_ticks++;
        end
        checks++;
        if (ack_ticks != 1) begin
            errors++;
            $display("FAIL early_drop_ack_len: got %0d cycles want 1", ack_ticks);
        end
        last_err = txn_err;
    endtask

    task automatic test_reset_mid_process();
        input_request = 1'b1;
        repeat (SYNC + 1 + 4) @(negedge clk);
        checks++;
        if (fsm_state !== 2'd1) begin
            errors++;
            $display("FAIL midreset_pre_process: got state=%0d want 1", fsm_state);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (pack_obs() !== 6'b0) begin
            errors++;
            $display("FAIL midreset_immediate: got %b want 000000", pack_obs());
        end
        @(negedge clk);
        rst = 1'b0;
        model_txn(0, 14, 1'b0);
        drive_txn(0, 14, 1'b0);
        for (int t = 0; t <= txn_len; t++) begin
            checks++;
            if (obs_v[t] !== exp_v[t]) begin
                errors++;
                $display("FAIL midreset_restart tick %0d: got %b want %b", t, obs_v[t], exp_v[t]);
            end
        end
        last_err = txn_err;
    endtask

    task automatic test_back_to_back();
        int d, f;
        for (int n = 0; n < 12; n++) begin
            d = int'($urandom_range(0, T + 3));
            f = int'($urandom_range(1, 30));
            model_txn(d, f, last_err);
            drive_txn(d, f, 1'b1);
            for (int t = 0; t <= txn_len; t++) begin
                checks++;
                if (obs_v[t] !== exp_v[t]) begin
                    errors++;
                    $display("FAIL back_to_back n=%0d d=%0d f=%0d tick %0d: got %b want %b",
                             n, d, f, t, obs_v[t], exp_v[t]);
                end
            end
            last_err = txn_err;
        end
    endtask

    initial begin
        last_err = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_nominal();
        test_timeout();
        test_simultaneous();
        test_hold();
        test_early_drop();
        test_reset_mid_process();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/handshake_sequencer.md
Name: handshake_sequencer

Overview:
- Owns the interface state machine that drives `fsm_state` (type `interface_state_t`) for the stream-cipher input reader.
- Sequences the chip-pin 4-phase handshake: request, ack, request release, ack release.
- Synchronizes the asynchronous `input_request` pin. Holds off new requests while the downstream operation (data router or hash generator) is in flight.
- Bounds the wait for the downstream operation with a timeout.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops on `input_request`; minimum 2.
- TIMEOUT_CYCLES, 255: maximum cycles spent in PROCESS before a forced ACK; minimum 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- input_request  input  1  raw request pin, asynchronous to clk
- op_done  input  1  single-cycle completion pulse from the data router or hash generator
- input_request_sync  output  1  synchronized request; feeds the reader's `input_request`
- fsm_state  output  2  `interface_state_t` value: IDLE=0, PROCESS=1, ACK=2 (3 unused)
- input_ack  output  1  handshake acknowledge pin, registered
- op_error  output  1  last operation timed out; sticky
- busy  output  1  high when fsm_state != IDLE

Behaviour:
- Reset (async assert, sync release):
  - all synchronizer flops 0, state IDLE, cycle counter 0
  - input_ack 0, op_error 0, busy 0
  - a reset mid-operation abandons the operation with no ack.
- Synchronizer: `input_request_sync` is the last of SYNC_STAGES flops. A pin change is visible SYNC_STAGES edges later.
- State register and all outputs are flops. `busy` and `fsm_state` decode directly from the state register.
- IDLE:
  - if `input_request_sync`=1 -> PROCESS at the next edge, counter cleared, op_error cleared.
  - This is the same edge at which the reader issues its pulse. Leaving IDLE on that edge guarantees exactly one pulse per request.
- PROCESS:
  - counter increments each cycle, width $clog2(TIMEOUT_CYCLES+1).
  - op_done=1 -> ACK, op_error stays 0.
  - Otherwise, counter == TIMEOUT_CYCLES-1 -> ACK with op_error set to 1. Total PROCESS dwell is exactly TIMEOUT_CYCLES cycles.
  - op_done and timeout in the same cycle: op_done wins, op_error=0.
  - `input_request_sync` is ignored in PROCESS, including an early drop of the request.
- ACK:
  - `input_ack` is set to 1 on the edge entering ACK and held.
  - If `input_request_sync`=0 -> IDLE, and `input_ack` is cleared on that same edge.
  - A request held high keeps the block in ACK indefinitely; no second operation starts.
- IDLE is re-entered only after request release, so a new request needs a fresh rising edge on the pin. Minimum one cycle in IDLE between operations.
- op_done pulses while in IDLE or ACK are ignored: no state change, no error change.
- op_error persists through ACK and IDLE until the next IDLE->PROCESS transition.
- State encoding 3 is unreachable. If it is ever entered, the next edge goes to IDLE with input_ack 0.
- Handshake latency, request pin rise to input_ack=1: SYNC_STAGES + 1 + (PROCESS dwell) edges.

Test Plan:
1. Reset:
   - assert rst mid-cycle with input_request=1.
   - Required immediately: fsm_state=0, input_ack=0, op_error=0, busy=0, input_request_sync=0.
   - After release: input_request_sync=1 exactly 2 edges later, PROCESS on the 3rd.
2. Nominal handshake (SYNC_STAGES=2):
   - raise request, then pulse op_done on the 5th cycle of PROCESS.
   - Required: ACK and input_ack=1 on the next edge, op_error=0.
   - Drop request: input_ack=0 and fsm_state=IDLE 3 edges after the pin falls.
3. Timeout (TIMEOUT_CYCLES=8), no op_done:
   - Required: ACK after exactly 8 PROCESS cycles, op_error=1 held through IDLE.
   - Next request: op_error=0 on the PROCESS entry edge.
4. Simultaneous events (TIMEOUT_CYCLES=8):
   - op_done on PROCESS cycle 8 -> ACK with op_error=0.
   - op_done pulses injected in IDLE and in ACK -> no state or output change.
5. Request held in ACK, and early drop:
   - request held high for 20 cycles in ACK -> stays ACK, exactly one IDLE->PROCESS transition, input_ack=1 throughout.
   - Separate run: request dropped during PROCESS -> still waits for op_done, then ACK for 1 cycle, then IDLE.
6. Reset mid-PROCESS (counter=4):
   - Required: immediate IDLE, input_ack=0, counter=0.
   - After release with request still high: a new operation starts SYNC_STAGES+1 edges later, and the timeout counts a full TIMEOUT_CYCLES.
